// File: rtl/flood_engine.sv
// Flood-It game engine: register-based board, raster recolour and
// repeated raster flood sweeps from origin (0,0), move/try bookkeeping
// and a 1-cycle-latency display read port.
module flood_engine #(
  parameter int MAX_SIZE = 26,
  parameter int IDX_W    = 5,
  parameter int COLOR_W  = 3
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [IDX_W-1:0]   SIZE,
  input  logic [7:0]         MAX_TRIES,
  input  logic               LOAD_EN,
  input  logic [IDX_W-1:0]   LOAD_ROW,
  input  logic [IDX_W-1:0]   LOAD_COL,
  input  logic [COLOR_W-1:0] LOAD_COLOR,
  input  logic               COLOR_SEL_SIG,
  input  logic [COLOR_W-1:0] COLOR_SELECTED,
  output logic               MOVE_ACK,
  output logic               BUSY,
  output logic               MOVE_DONE,
  output logic [7:0]         TRIES,
  output logic               WON,
  output logic               LOST,
  input  logic [IDX_W-1:0]   RD_ROW,
  input  logic [IDX_W-1:0]   RD_COL,
  output logic [COLOR_W-1:0] RD_COLOR
);

  // One extra bit so MAX_SIZE itself and SIZE-1 compare without wrap.
  localparam int SW    = IDX_W + 1;
  localparam int CNT_W = 2 * SW;
  localparam logic [SW-1:0] LP_MAX = SW'(MAX_SIZE);
  localparam logic [SW-1:0] LP_TWO = SW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECOLOR,
    S_SWEEP,
    S_CHECK,
    S_READY
  } state_t;

  state_t             r_state;
  logic [SW-1:0]      r_size;
  logic [7:0]         r_max;
  logic [7:0]         r_tries;
  logic               r_won;
  logic               r_lost;
  logic               r_ack;
  logic               r_done;
  logic [COLOR_W-1:0] r_c;
  logic [IDX_W-1:0]   r_ri;
  logic [IDX_W-1:0]   r_ci;
  logic               r_added;
  logic [CNT_W-1:0]   r_cnt;
  logic [COLOR_W-1:0] r_col [MAX_SIZE][MAX_SIZE];
  logic               r_own [MAX_SIZE][MAX_SIZE];
  logic [COLOR_W-1:0] r_rd;

  logic [SW-1:0]      w_size_clamp;
  logic               w_last_r;
  logic               w_last_c;
  logic               w_scan_end;
  logic [IDX_W-1:0]   w_rm;
  logic [IDX_W-1:0]   w_rp;
  logic [IDX_W-1:0]   w_cm;
  logic [IDX_W-1:0]   w_cp;
  logic [IDX_W-1:0]   w_ri_nx;
  logic [IDX_W-1:0]   w_ci_nx;
  logic               w_nbr;
  logic               w_grow;
  logic [CNT_W-1:0]   w_area;
  logic               w_won_now;
  logic               w_ld_ok;
  logic               w_rd_ok;
  logic               w_move_ok;

  assign w_size_clamp = ({1'b0, SIZE} < LP_TWO) ? LP_TWO :
                        ({1'b0, SIZE} > LP_MAX) ? LP_MAX : {1'b0, SIZE};

  // Raster scan position bookkeeping over the active SIZE x SIZE window.
  assign w_last_r   = ({1'b0, r_ri} == r_size - SW'(1));
  assign w_last_c   = ({1'b0, r_ci} == r_size - SW'(1));
  assign w_scan_end = w_last_r & w_last_c;
  assign w_ci_nx    = w_last_c ? '0 : r_ci + IDX_W'(1);
  assign w_ri_nx    = w_last_c ? (w_last_r ? '0 : r_ri + IDX_W'(1)) : r_ri;

  // Neighbour indices are clamped so every array access stays in range;
  // the edge qualifiers in w_nbr discard the clamped (self) lookups.
  assign w_rm = (r_ri == '0) ? r_ri : r_ri - IDX_W'(1);
  assign w_rp = w_last_r     ? r_ri : r_ri + IDX_W'(1);
  assign w_cm = (r_ci == '0) ? r_ci : r_ci - IDX_W'(1);
  assign w_cp = w_last_c     ? r_ci : r_ci + IDX_W'(1);

  // Owned bits are read live, so cells captured earlier in this sweep count.
  assign w_nbr = ((r_ri != '0) && r_own[w_rm][r_ci]) ||
                 (!w_last_r    && r_own[w_rp][r_ci]) ||
                 ((r_ci != '0) && r_own[r_ri][w_cm]) ||
                 (!w_last_c    && r_own[r_ri][w_cp]);

  assign w_grow = !r_own[r_ri][r_ci] && (r_col[r_ri][r_ci] == r_c) && w_nbr;

  assign w_area    = CNT_W'(r_size) * CNT_W'(r_size);
  assign w_won_now = (r_cnt == w_area);

  assign w_ld_ok = LOAD_EN && ({1'b0, LOAD_ROW} < LP_MAX) && ({1'b0, LOAD_COL} < LP_MAX);
  assign w_rd_ok = ({1'b0, RD_ROW} < LP_MAX) && ({1'b0, RD_COL} < LP_MAX);

  assign w_move_ok = COLOR_SEL_SIG && !r_won && !r_lost && (COLOR_SELECTED != r_col[0][0]);

  // Control FSM and board state; RESET beats START, START beats everything else.
  always_ff @(posedge CLOCK) begin
    r_ack  <= 1'b0;
    r_done <= 1'b0;
    if (RESET) begin
      r_state <= S_IDLE;
      r_size  <= LP_TWO;
      r_max   <= '0;
      r_tries <= '0;
      r_won   <= 1'b0;
      r_lost  <= 1'b0;
      r_c     <= '0;
      r_ri    <= '0;
      r_ci    <= '0;
      r_added <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < MAX_SIZE; i++) begin
        for (int j = 0; j < MAX_SIZE; j++) begin
          r_col[i][j] <= '0;
          r_own[i][j] <= 1'b0;
        end
      end
    end else if (START) begin
      r_size  <= w_size_clamp;
      r_max   <= MAX_TRIES;
      r_tries <= '0;
      r_won   <= 1'b0;
      r_lost  <= 1'b0;
      r_c     <= r_col[0][0];
      r_ri    <= '0;
      r_ci    <= '0;
      r_added <= 1'b0;
      r_cnt   <= CNT_W'(1);
      for (int i = 0; i < MAX_SIZE; i++) begin
        for (int j = 0; j < MAX_SIZE; j++) begin
          r_own[i][j] <= 1'b0;
        end
      end
      r_own[0][0] <= 1'b1;
      r_state     <= S_SWEEP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ld_ok) r_col[LOAD_ROW][LOAD_COL] <= LOAD_COLOR;
        end
        S_READY: begin
          if (w_move_ok) begin
            r_ack   <= 1'b1;
            r_c     <= COLOR_SELECTED;
            r_tries <= (r_tries == 8'hFF) ? r_tries : r_tries + 8'd1;
            r_ri    <= '0;
            r_ci    <= '0;
            r_state <= S_RECOLOR;
          end
        end
        S_RECOLOR: begin
          if (r_own[r_ri][r_ci]) r_col[r_ri][r_ci] <= r_c;
          r_ri <= w_ri_nx;
          r_ci <= w_ci_nx;
          if (w_scan_end) begin
            r_added <= 1'b0;
            r_state <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (w_grow) begin
            r_own[r_ri][r_ci] <= 1'b1;
            r_cnt             <= r_cnt + CNT_W'(1);
            r_added           <= 1'b1;
          end
          r_ri <= w_ri_nx;
          r_ci <= w_ci_nx;
          // Another pass is needed whenever this one captured anything.
          if (w_scan_end) begin
            r_added <= 1'b0;
            if (!(r_added || w_grow)) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_won   <= w_won_now;
          r_lost  <= !w_won_now && (r_max != 8'd0) && (r_tries >= r_max);
          r_done  <= 1'b1;
          r_state <= S_READY;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Display read port: always live, out-of-range addresses return 0.
  always_ff @(posedge CLOCK) begin
    if (RESET)        r_rd <= '0;
    else if (w_rd_ok) r_rd <= r_col[RD_ROW][RD_COL];
    else              r_rd <= '0;
  end

  assign BUSY      = (r_state == S_RECOLOR) || (r_state == S_SWEEP) || (r_state == S_CHECK);
  assign MOVE_ACK  = r_ack;
  assign MOVE_DONE = r_done;
  assign TRIES     = r_tries;
  assign WON       = r_won;
  assign LOST      = r_lost;
  assign RD_COLOR  = r_rd;

endmodule

// File: tb/tb_flood_engine.sv
// Bench for flood_engine: a transaction-level game model (board arrays,
// queue flood fill, latency from pass count) checked every cycle, plus
// directed games with hand-computed latencies and flags.
module tb_flood_engine;
  localparam int MS = 26;
  localparam int IW = 5;
  localparam int CW = 3;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic [IW-1:0] SIZE = '0;
  logic [7:0]    MAX_TRIES = '0;
  logic          LOAD_EN = 1'b0;
  logic [IW-1:0] LOAD_ROW = '0;
  logic [IW-1:0] LOAD_COL = '0;
  logic [CW-1:0] LOAD_COLOR = '0;
  logic          COLOR_SEL_SIG = 1'b0;
  logic [CW-1:0] COLOR_SELECTED = '0;
  logic [IW-1:0] RD_ROW = '0;
  logic [IW-1:0] RD_COL = '0;
  logic          MOVE_ACK, BUSY, MOVE_DONE, WON, LOST;
  logic [7:0]    TRIES;
  logic [CW-1:0] RD_COLOR;

  int checks = 0;
  int errors = 0;

  flood_engine #(.MAX_SIZE(MS), .IDX_W(IW), .COLOR_W(CW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .SIZE(SIZE), .MAX_TRIES(MAX_TRIES),
    .LOAD_EN(LOAD_EN), .LOAD_ROW(LOAD_ROW), .LOAD_COL(LOAD_COL), .LOAD_COLOR(LOAD_COLOR),
    .COLOR_SEL_SIG(COLOR_SEL_SIG), .COLOR_SELECTED(COLOR_SELECTED),
    .MOVE_ACK(MOVE_ACK), .BUSY(BUSY), .MOVE_DONE(MOVE_DONE), .TRIES(TRIES),
    .WON(WON), .LOST(LOST), .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_COLOR(RD_COLOR)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int m_col [MS][MS];
  bit m_own [MS][MS];
  int m_n, m_c, m_max, m_tries, m_left, m_state, m_rd;
  bit m_won, m_lost, m_busy, m_ack, m_done, m_init = 0;

  function automatic bit nb(input bit a[MS][MS], input int r, input int c, input int n);
    bit v;
    v = 0;
    if (r > 0     && a[r-1][c]) v = 1;
    if (r < n - 1 && a[r+1][c]) v = 1;
    if (c > 0     && a[r][c-1]) v = 1;
    if (c < n - 1 && a[r][c+1]) v = 1;
    return v;
  endfunction

  // Ownership from a queue flood fill; sw = raster passes until a pass adds nothing.
  task automatic m_flood(output int sw);
    bit t [MS][MS];
    bit ch;
    int q[$];
    int k, r, c, rr, cc;
    int dr[4] = '{-1, 1, 0, 0};
    int dc[4] = '{0, 0, -1, 1};
    t = m_own;
    sw = 0;
    do begin
      ch = 0;
      sw++;
      for (int i = 0; i < m_n; i++)
        for (int j = 0; j < m_n; j++)
          if (!t[i][j] && m_col[i][j] == m_c && nb(t, i, j, m_n)) begin
            t[i][j] = 1;
            ch = 1;
          end
    end while (ch);
    for (int i = 0; i < m_n; i++)
      for (int j = 0; j < m_n; j++)
        if (m_own[i][j]) q.push_back(i * MS + j);
    while (q.size() > 0) begin
      k = q.pop_front();
      r = k / MS;
      c = k % MS;
      for (int d = 0; d < 4; d++) begin
        rr = r + dr[d];
        cc = c + dc[d];
        if (rr >= 0 && rr < m_n && cc >= 0 && cc < m_n && !m_own[rr][cc] && m_col[rr][cc] == m_c) begin
          m_own[rr][cc] = 1;
          q.push_back(rr * MS + cc);
        end
      end
    end
  endtask

  always @(posedge CLOCK) begin
    int sw, cnt;
    m_ack  = 0;
    m_done = 0;
    if (RESET) begin
      m_init = 1;
      for (int i = 0; i < MS; i++)
        for (int j = 0; j < MS; j++) begin
          m_col[i][j] = 0;
          m_own[i][j] = 0;
        end
      m_state = 0; m_busy = 0; m_won = 0; m_lost = 0; m_tries = 0; m_rd = 0;
      m_n = 2; m_c = 0; m_max = 0; m_left = 0;
    end else begin
      m_rd = (RD_ROW < MS && RD_COL < MS) ? m_col[RD_ROW][RD_COL] : 0;
      if (START) begin
        m_n = (SIZE < 2) ? 2 : (SIZE > MS) ? MS : int'(SIZE);
        m_max = MAX_TRIES;
        m_tries = 0; m_won = 0; m_lost = 0;
        for (int i = 0; i < MS; i++)
          for (int j = 0; j < MS; j++) m_own[i][j] = 0;
        m_own[0][0] = 1;
        m_c = m_col[0][0];
        m_flood(sw);
        m_left = m_n * m_n * sw + 1;
        m_state = 1; m_busy = 1;
      end else if (m_state == 0) begin
        if (LOAD_EN && LOAD_ROW < MS && LOAD_COL < MS) m_col[LOAD_ROW][LOAD_COL] = LOAD_COLOR;
      end else if (m_state == 2) begin
        if (COLOR_SEL_SIG && !m_won && !m_lost && COLOR_SELECTED != m_col[0][0]) begin
          m_ack = 1;
          m_tries = (m_tries == 255) ? 255 : m_tries + 1;
          m_c = COLOR_SELECTED;
          for (int i = 0; i < m_n; i++)
            for (int j = 0; j < m_n; j++)
              if (m_own[i][j]) m_col[i][j] = m_c;
          m_flood(sw);
          m_left = m_n * m_n * (1 + sw) + 1;
          m_state = 1; m_busy = 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          cnt = 0;
          for (int i = 0; i < m_n; i++)
            for (int j = 0; j < m_n; j++) cnt += m_own[i][j];
          m_won  = (cnt == m_n * m_n);
          m_lost = !m_won && m_max != 0 && m_tries >= m_max;
          m_done = 1; m_busy = 0; m_state = 2;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK) begin
    if (m_init) begin
      chk("busy", BUSY, m_busy);
      chk("move_ack", MOVE_ACK, m_ack);
      chk("move_done", MOVE_DONE, m_done);
      chk("tries", TRIES, m_tries);
      chk("won", WON, m_won);
      chk("lost", LOST, m_lost);
      if (!m_busy) chk("rd_color", RD_COLOR, m_rd);
    end
  end

  // ---------------- stimulus ----------------
  int b3 [3][3] = '{'{1, 2, 3}, '{2, 3, 1}, '{3, 1, 2}};
  int b5 [5][5] = '{'{1, 3, 2, 3, 3}, '{2, 3, 2, 3, 2}, '{2, 3, 2, 3, 2},
                    '{2, 3, 2, 3, 2}, '{2, 3, 3, 3, 2}};

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic load(input int r, input int c, input int v);
    LOAD_EN = 1; LOAD_ROW = IW'(r); LOAD_COL = IW'(c); LOAD_COLOR = CW'(v);
    @(negedge CLOCK);
    LOAD_EN = 0;
  endtask

  task automatic start_game(input int sz, input int mx);
    SIZE = IW'(sz); MAX_TRIES = 8'(mx); START = 1;
    @(negedge CLOCK);
    START = 0;
  endtask

  task automatic move(input int v);
    COLOR_SEL_SIG = 1; COLOR_SELECTED = CW'(v);
    @(negedge CLOCK);
    COLOR_SEL_SIG = 0;
  endtask

  task automatic rd(input int r, input int c, output int v);
    RD_ROW = IW'(r); RD_COL = IW'(c);
    @(negedge CLOCK);
    v = RD_COLOR;
  endtask

  task automatic scan(input int n);
    int v;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) rd(r, c, v);
  endtask

  // Counts cycles from the accepting edge to MOVE_DONE; kind 1 pokes a move
  // request, kind 2 pokes START (which restarts the count).
  task automatic wait_done(input int poke_at, input int kind, input int pc, output int cyc);
    int n;
    bit pk;
    n = 0;
    cyc = 0;
    while (1) begin
      pk = (n == poke_at);
      if (pk && kind == 1) begin COLOR_SEL_SIG = 1; COLOR_SELECTED = CW'(pc); end
      if (pk && kind == 2) START = 1;
      @(negedge CLOCK);
      COLOR_SEL_SIG = 0;
      START = 0;
      n++;
      if (pk && kind == 2) cyc = 0; else cyc++;
      if (pk && kind == 1) chk("busy_request_ack", MOVE_ACK, 0);
      if (pk && kind == 2) chk("restart_tries", TRIES, 0);
      if (MOVE_DONE) break;
      if (n > 3000) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int cyc, v;
    tick(3);
    RESET = 0;
    chk("reset_busy", BUSY, 0);
    chk("reset_tries", TRIES, 0);
    chk("reset_won", WON, 0);

    // 2x2 game: 1,2 / 2,2 plus an ignored out-of-range load
    load(0, 0, 1); load(0, 1, 2); load(1, 0, 2); load(1, 1, 2);
    load(27, 0, 5);
    rd(27, 0, v);  chk("rd_out_of_range", v, 0);
    start_game(2, 0);
    wait_done(-1, 0, 0, cyc); chk("start_latency_2x2", cyc, 5);
    chk("start_won", WON, 0);
    move(1); chk("same_colour_ack", MOVE_ACK, 0);
    tick(1); chk("same_colour_tries", TRIES, 0);
    move(2); chk("move_ack", MOVE_ACK, 1);
    wait_done(3, 1, 3, cyc); chk("move_latency_2x2", cyc, 13);
    chk("won_2x2", WON, 1);
    chk("tries_2x2", TRIES, 1);
    move(1); chk("after_win_ack", MOVE_ACK, 0);
    tick(1); chk("after_win_tries", TRIES, 1);
    scan(2);

    // size clamping on an all-zero board
    RESET = 1; tick(2); RESET = 0;
    start_game(0, 0);
    wait_done(-1, 0, 0, cyc); chk("clamp_low_latency", cyc, 9);
    chk("clamp_low_won", WON, 1);
    start_game(31, 0);
    wait_done(-1, 0, 0, cyc); chk("clamp_high_latency", cyc, 1353);
    chk("clamp_high_won", WON, 1);

    // 3x3 game with MAX_TRIES=1, START abort during SWEEP, then a losing move
    RESET = 1; tick(2); RESET = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) load(r, c, b3[r][c]);
    start_game(3, 1);
    wait_done(-1, 0, 0, cyc); chk("start_latency_3x3", cyc, 10);
    move(2); chk("abort_move_ack", MOVE_ACK, 1);
    wait_done(12, 2, 0, cyc); chk("restart_latency", cyc, 19);
    chk("restart_tries_done", TRIES, 0);
    move(3); chk("lose_move_ack", MOVE_ACK, 1);
    wait_done(-1, 0, 0, cyc); chk("lose_latency", cyc, 28);
    chk("lost_flag", LOST, 1);
    chk("lost_won", WON, 0);
    move(1); chk("after_loss_ack", MOVE_ACK, 0);
    tick(1); chk("after_loss_tries", TRIES, 1);
    scan(3);

    // RESET during RECOLOR
    start_game(3, 1);
    wait_done(-1, 0, 0, cyc); chk("restart_3x3_latency", cyc, 19);
    move(1); chk("reset_move_ack", MOVE_ACK, 1);
    tick(3);
    RESET = 1; tick(2); RESET = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("no_done_after_reset", MOVE_DONE, 0);
    end
    chk("reset_mid_busy", BUSY, 0);
    chk("reset_mid_tries", TRIES, 0);
    rd(0, 0, v); chk("reset_mid_color", v, 0);

    // 5x5 snake needing backward propagation
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) load(r, c, b5[r][c]);
    load(27, 1, 3);
    start_game(5, 0);
    wait_done(-1, 0, 0, cyc); chk("snake_start_latency", cyc, 26);
    move(3);
    wait_done(-1, 0, 0, cyc); chk("snake_latency", cyc, 176);
    chk("snake_won", WON, 0);
    move(4);
    wait_done(-1, 0, 0, cyc); chk("snake_paint_latency", cyc, 51);
    rd(0, 0, v); chk("owned_00", v, 4);
    rd(0, 4, v); chk("owned_04", v, 4);
    rd(4, 2, v); chk("owned_42", v, 4);
    rd(0, 2, v); chk("unowned_02", v, 2);
    rd(1, 0, v); chk("unowned_10", v, 2);
    scan(5);
    move(2);
    wait_done(-1, 0, 0, cyc); chk("snake_final_latency", cyc, 76);
    chk("snake_final_won", WON, 1);
    chk("snake_final_tries", TRIES, 3);
    scan(5);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
